// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - RV32 decode stage with register file, bypass, load-use stall and ID/EX register
module ControlUnit #(
  parameter int ALU_SEL_W = 6
) (
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  output logic [ALU_SEL_W-1:0] aluSelect,
  output logic                 regWrite,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 immSelect,
  output logic                 pcSelect,
  output logic                 jType
);
  logic [5:0] aluOp;

  // aluOp: {class[1:0], alt, funct3}; class 00 arith/logic, 01 pass-immediate, 10 branch compare
  always_comb begin
    aluOp     = 6'd0;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    immSelect = 1'b0;
    pcSelect  = 1'b0;
    jType     = 1'b0;
    case (opcode)
      7'b0110011: begin
        regWrite = 1'b1;
        aluOp    = {2'b00, funct7b5, funct3};
      end
      7'b0010011: begin
        regWrite  = 1'b1;
        immSelect = 1'b1;
        aluOp     = {2'b00, (funct3 == 3'b101) & funct7b5, funct3};
      end
      7'b0000011: begin
        regWrite  = 1'b1;
        memRead   = 1'b1;
        immSelect = 1'b1;
      end
      7'b0100011: begin
        memWrite  = 1'b1;
        immSelect = 1'b1;
      end
      7'b1100011: begin
        pcSelect = 1'b1;
        aluOp    = {3'b100, funct3};
      end
      7'b1101111, 7'b1100111: begin
        regWrite  = 1'b1;
        pcSelect  = 1'b1;
        jType     = 1'b1;
        immSelect = 1'b1;
      end
      7'b0110111: begin
        regWrite  = 1'b1;
        immSelect = 1'b1;
        aluOp     = 6'b010000;
      end
      7'b0010111: begin
        regWrite  = 1'b1;
        immSelect = 1'b1;
      end
      default: ;
    endcase
  end

  assign aluSelect = ALU_SEL_W'(aluOp);
endmodule

module ImmGen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = 32'd0;
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      7'b0100011:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {instr[31:12], 12'd0};
      7'b1101111:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: ;
    endcase
  end

  assign imm = XLEN'($signed(imm32));
endmodule

module decode_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int AW        = $clog2(NREG),
  parameter int ALU_SEL_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr_d,
  input  logic [XLEN-1:0]      pc_d,
  input  logic                 valid_d,
  input  logic                 stall_e,
  input  logic                 flush_d,
  input  logic                 reg_write_w,
  input  logic [AW-1:0]        write_addr_w,
  input  logic [XLEN-1:0]      write_data_w,
  output logic                 stall_f,
  output logic                 valid_e,
  output logic [XLEN-1:0]      pc_e,
  output logic [XLEN-1:0]      read_out1_e,
  output logic [XLEN-1:0]      read_out2_e,
  output logic [XLEN-1:0]      imm_e,
  output logic [AW-1:0]        rs1_e,
  output logic [AW-1:0]        rs2_e,
  output logic [AW-1:0]        write_address_e,
  output logic [ALU_SEL_W-1:0] alu_select_e,
  output logic                 reg_write_e,
  output logic                 mem_read_e,
  output logic                 mem_write_e,
  output logic                 imm_select_e,
  output logic                 pc_select_e,
  output logic                 jtype_e
);
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      imm;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic [AW-1:0]        rd;
    logic [ALU_SEL_W-1:0] alu;
    logic                 regWrite;
    logic                 memRead;
    logic                 memWrite;
    logic                 immSelect;
    logic                 pcSelect;
    logic                 jType;
  } idexEntry;

  logic [4:0]           rs1Field, rs2Field, rdField;
  logic [AW-1:0]        rs1D, rs2D, rdD;
  logic                 rdInRange;
  logic [XLEN-1:0]      regFile [NREG];
  logic [XLEN-1:0]      readData1, readData2, immD;
  logic [ALU_SEL_W-1:0] aluD;
  logic                 cuRegWrite, memReadD, memWriteD, immSelectD, pcSelectD, jTypeD;
  logic                 hazard, bubble;
  idexEntry             idEx, decoded;

  // Fields naming registers beyond NREG behave like x0: read as zero, never written
  assign rs1Field  = instr_d[19:15];
  assign rs2Field  = instr_d[24:20];
  assign rdField   = instr_d[11:7];
  assign rs1D      = (32'(rs1Field) < NREG) ? rs1Field[AW-1:0] : '0;
  assign rs2D      = (32'(rs2Field) < NREG) ? rs2Field[AW-1:0] : '0;
  assign rdInRange = 32'(rdField) < NREG;
  assign rdD       = rdInRange ? rdField[AW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regFile[i] <= '0;
    end else if (reg_write_w && write_addr_w != '0) begin
      regFile[write_addr_w] <= write_data_w;
    end
  end

  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (rs1D != '0) begin
      if (reg_write_w && write_addr_w == rs1D) readData1 = write_data_w;
      else                                     readData1 = regFile[rs1D];
    end
    if (rs2D != '0) begin
      if (reg_write_w && write_addr_w == rs2D) readData2 = write_data_w;
      else                                     readData2 = regFile[rs2D];
    end
  end

  ControlUnit #(.ALU_SEL_W(ALU_SEL_W)) controlUnit (
    .opcode   (instr_d[6:0]),
    .funct3   (instr_d[14:12]),
    .funct7b5 (instr_d[30]),
    .aluSelect(aluD),
    .regWrite (cuRegWrite),
    .memRead  (memReadD),
    .memWrite (memWriteD),
    .immSelect(immSelectD),
    .pcSelect (pcSelectD),
    .jType    (jTypeD)
  );

  ImmGen #(.XLEN(XLEN)) immGen (
    .instr(instr_d),
    .imm  (immD)
  );

  // Both source fields are compared regardless of format; a spurious stall is harmless
  assign hazard  = valid_d & idEx.valid & idEx.memRead & (idEx.rd != '0) &
                   ((idEx.rd == rs1D) | (idEx.rd == rs2D));
  assign stall_f = stall_e | (hazard & ~flush_d);
  assign bubble  = flush_d | hazard | ~valid_d;

  always_comb begin
    decoded           = '0;
    decoded.valid     = 1'b1;
    decoded.pc        = pc_d;
    decoded.rd1       = readData1;
    decoded.rd2       = readData2;
    decoded.imm       = immD;
    decoded.rs1       = rs1D;
    decoded.rs2       = rs2D;
    decoded.rd        = rdD;
    decoded.alu       = aluD;
    decoded.regWrite  = cuRegWrite & rdInRange;
    decoded.memRead   = memReadD;
    decoded.memWrite  = memWriteD;
    decoded.immSelect = immSelectD;
    decoded.pcSelect  = pcSelectD;
    decoded.jType     = jTypeD;
  end

  always_ff @(posedge clk) begin
    if (reset)         idEx <= '0;
    else if (!stall_e) idEx <= bubble ? '0 : decoded;
  end

  assign valid_e         = idEx.valid;
  assign pc_e            = idEx.pc;
  assign read_out1_e     = idEx.rd1;
  assign read_out2_e     = idEx.rd2;
  assign imm_e           = idEx.imm;
  assign rs1_e           = idEx.rs1;
  assign rs2_e           = idEx.rs2;
  assign write_address_e = idEx.rd;
  assign alu_select_e    = idEx.alu;
  assign reg_write_e     = idEx.regWrite;
  assign mem_read_e      = idEx.memRead;
  assign mem_write_e     = idEx.memWrite;
  assign imm_select_e    = idEx.immSelect;
  assign pc_select_e     = idEx.pcSelect;
  assign jtype_e         = idEx.jType;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - scoreboard bench for decode_stage_pipe (RV32I and RV32E instances)
module tb_decode_stage_pipe;
  typedef struct {
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  ctrl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  exp_t qE[$];

  logic        reset, validD, stallE, flushD, regWriteW;
  logic [31:0] instrD, pcD, writeDataW;
  logic [4:0]  writeAddrW;
  logic        stallF, validE, regWriteE, memReadE, memWriteE, immSelectE, pcSelectE, jtypeE;
  logic [31:0] pcE, readOut1E, readOut2E, immE;
  logic [4:0]  rs1E, rs2E, writeAddressE;
  logic [5:0]  aluSelectE;

  logic        eReset, eValidD, eStallE, eFlushD, eRegWriteW;
  logic [31:0] eInstrD, ePcD, eWriteDataW;
  logic [3:0]  eWriteAddrW;
  logic        eStallF, eValidE, eRegWriteE, eMemReadE, eMemWriteE, eImmSelectE, ePcSelectE, eJtypeE;
  logic [31:0] ePcE, eReadOut1E, eReadOut2E, eImmE;
  logic [3:0]  eRs1E, eRs2E, eWriteAddressE;
  logic [5:0]  eAluSelectE;

  decode_stage_pipe dut (
    .clk(clk), .reset(reset), .instr_d(instrD), .pc_d(pcD), .valid_d(validD),
    .stall_e(stallE), .flush_d(flushD), .reg_write_w(regWriteW),
    .write_addr_w(writeAddrW), .write_data_w(writeDataW), .stall_f(stallF),
    .valid_e(validE), .pc_e(pcE), .read_out1_e(readOut1E), .read_out2_e(readOut2E),
    .imm_e(immE), .rs1_e(rs1E), .rs2_e(rs2E), .write_address_e(writeAddressE),
    .alu_select_e(aluSelectE), .reg_write_e(regWriteE), .mem_read_e(memReadE),
    .mem_write_e(memWriteE), .imm_select_e(immSelectE), .pc_select_e(pcSelectE),
    .jtype_e(jtypeE)
  );

  decode_stage_pipe #(.NREG(16)) dutE (
    .clk(clk), .reset(eReset), .instr_d(eInstrD), .pc_d(ePcD), .valid_d(eValidD),
    .stall_e(eStallE), .flush_d(eFlushD), .reg_write_w(eRegWriteW),
    .write_addr_w(eWriteAddrW), .write_data_w(eWriteDataW), .stall_f(eStallF),
    .valid_e(eValidE), .pc_e(ePcE), .read_out1_e(eReadOut1E), .read_out2_e(eReadOut2E),
    .imm_e(eImmE), .rs1_e(eRs1E), .rs2_e(eRs2E), .write_address_e(eWriteAddressE),
    .alu_select_e(eAluSelectE), .reg_write_e(eRegWriteE), .mem_read_e(eMemReadE),
    .mem_write_e(eMemWriteE), .imm_select_e(eImmSelectE), .pc_select_e(ePcSelectE),
    .jtype_e(eJtypeE)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // ctrl = {reg_write, mem_read, mem_write, imm_select, pc_select, jtype}
  function automatic exp_t mk(logic [31:0] pc, logic [31:0] r1, logic [31:0] r2, logic [31:0] imm,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [5:0] ctrl);
    exp_t e;
    e.pc = pc; e.r1 = r1; e.r2 = r2; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ctrl = ctrl;
    return e;
  endfunction

  logic lastStall = 1'b0;
  always @(posedge clk) lastStall <= stallE;

  always @(negedge clk) begin
    exp_t e;
    if (validE && !lastStall) begin
      if (q.size() == 0) begin
        chk("unexpected entry pc", 64'(pcE), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("pc_e", 64'(pcE), 64'(e.pc));
        chk("read_out1_e", 64'(readOut1E), 64'(e.r1));
        chk("read_out2_e", 64'(readOut2E), 64'(e.r2));
        chk("imm_e", 64'(immE), 64'(e.imm));
        chk("rs1_e", 64'(rs1E), 64'(e.rs1));
        chk("rs2_e", 64'(rs2E), 64'(e.rs2));
        chk("write_address_e", 64'(writeAddressE), 64'(e.rd));
        chk("alu_select_e", 64'(aluSelectE), 64'h0);
        chk("ctrl_e", 64'({regWriteE, memReadE, memWriteE, immSelectE, pcSelectE, jtypeE}), 64'(e.ctrl));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (eValidE) begin
      if (qE.size() == 0) begin
        chk("rv32e unexpected entry pc", 64'(ePcE), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = qE.pop_front();
        chk("rv32e pc_e", 64'(ePcE), 64'(e.pc));
        chk("rv32e read_out1_e", 64'(eReadOut1E), 64'(e.r1));
        chk("rv32e read_out2_e", 64'(eReadOut2E), 64'(e.r2));
        chk("rv32e imm_e", 64'(eImmE), 64'(e.imm));
        chk("rv32e rs1_e", 64'(eRs1E), 64'(e.rs1));
        chk("rv32e rs2_e", 64'(eRs2E), 64'(e.rs2));
        chk("rv32e write_address_e", 64'(eWriteAddressE), 64'(e.rd));
        chk("rv32e ctrl_e", 64'({eRegWriteE, eMemReadE, eMemWriteE, eImmSelectE, ePcSelectE, eJtypeE}), 64'(e.ctrl));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    instrD = instr; pcD = pc; validD = 1'b1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    validD = 1'b0; regWriteW = 1'b1; writeAddrW = a; writeDataW = d;
    step();
    regWriteW = 1'b0;
  endtask

  task automatic eWr(input logic [3:0] a, input logic [31:0] d);
    eValidD = 1'b0; eRegWriteW = 1'b1; eWriteAddrW = a; eWriteDataW = d;
    step();
    eRegWriteW = 1'b0;
  endtask

  localparam logic [5:0] ADD_C = 6'b100000;
  localparam logic [5:0] LW_C  = 6'b110100;

  initial begin
    reset = 1'b1; validD = 1'b0; stallE = 1'b0; flushD = 1'b0; regWriteW = 1'b0;
    instrD = '0; pcD = '0; writeAddrW = '0; writeDataW = '0;
    eReset = 1'b1; eValidD = 1'b0; eStallE = 1'b0; eFlushD = 1'b0; eRegWriteW = 1'b0;
    eInstrD = '0; ePcD = '0; eWriteAddrW = '0; eWriteDataW = '0;
    step(); step();
    reset = 1'b0; eReset = 1'b0;

    chk("reset valid_e", 64'(validE), 64'h0);
    chk("reset pc_e", 64'(pcE), 64'h0);
    chk("reset read_out1_e", 64'(readOut1E), 64'h0);
    chk("reset imm_e", 64'(immE), 64'h0);
    chk("reset ctrl", 64'({regWriteE, memReadE, memWriteE, immSelectE, pcSelectE, jtypeE}), 64'h0);
    chk("reset stall_f", 64'(stallF), 64'h0);
    chk("reset rv32e valid_e", 64'(eValidE), 64'h0);

    wr(5'd1, 32'd5);
    wr(5'd2, 32'd7);

    // basic decode
    issue(32'h002081B3, 32'h100);
    q.push_back(mk(32'h100, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, ADD_C));
    #1 chk("basic stall_f", 64'(stallF), 64'h0);
    step();

    // same-cycle write-back bypass, then x0 write discarded
    issue(32'h002081B3, 32'h104);
    regWriteW = 1'b1; writeAddrW = 5'd1; writeDataW = 32'hDEAD;
    q.push_back(mk(32'h104, 32'hDEAD, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, ADD_C));
    step();
    issue(32'h002001B3, 32'h108);
    writeAddrW = 5'd0; writeDataW = 32'hBEEF;
    q.push_back(mk(32'h108, 32'd0, 32'd7, 32'd0, 5'd0, 5'd2, 5'd3, ADD_C));
    step();
    regWriteW = 1'b0;

    // load-use: LW x5 then ADD x6,x5,x2
    issue(32'h0000A283, 32'h200);
    q.push_back(mk(32'h200, 32'hDEAD, 32'd0, 32'd0, 5'd1, 5'd0, 5'd5, LW_C));
    #1 chk("lw stall_f", 64'(stallF), 64'h0);
    step();
    issue(32'h00228333, 32'h204);
    #1 chk("load-use stall_f", 64'(stallF), 64'h1);
    step();
    chk("bubble valid_e", 64'(validE), 64'h0);
    chk("bubble reg_write_e", 64'(regWriteE), 64'h0);
    chk("bubble mem_read_e", 64'(memReadE), 64'h0);
    chk("after bubble stall_f", 64'(stallF), 64'h0);
    regWriteW = 1'b1; writeAddrW = 5'd5; writeDataW = 32'h55;
    q.push_back(mk(32'h204, 32'h55, 32'd7, 32'd0, 5'd5, 5'd2, 5'd6, ADD_C));
    step();
    regWriteW = 1'b0;

    // LW x0 followed by a user of x0: no stall
    issue(32'h0000A003, 32'h300);
    q.push_back(mk(32'h300, 32'hDEAD, 32'd0, 32'd0, 5'd1, 5'd0, 5'd0, LW_C));
    step();
    issue(32'h002003B3, 32'h304);
    #1 chk("lw x0 stall_f", 64'(stallF), 64'h0);
    q.push_back(mk(32'h304, 32'd0, 32'd7, 32'd0, 5'd0, 5'd2, 5'd7, ADD_C));
    step();

    // downstream hold for 3 cycles
    issue(32'h002081B3, 32'h400);
    q.push_back(mk(32'h400, 32'hDEAD, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, ADD_C));
    step();
    stallE = 1'b1;
    issue(32'h00228333, 32'h404);
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold stall_f", 64'(stallF), 64'h1);
      step();
      chk("hold valid_e", 64'(validE), 64'h1);
      chk("hold pc_e", 64'(pcE), 64'h400);
      chk("hold read_out1_e", 64'(readOut1E), 64'hDEAD);
      chk("hold write_address_e", 64'(writeAddressE), 64'h3);
      chk("hold reg_write_e", 64'(regWriteE), 64'h1);
    end
    stallE = 1'b0;
    q.push_back(mk(32'h404, 32'h55, 32'd7, 32'd0, 5'd5, 5'd2, 5'd6, ADD_C));
    #1 chk("release stall_f", 64'(stallF), 64'h0);
    step();

    // flush of a SW without hazard
    issue(32'h0020A223, 32'h500);
    flushD = 1'b1;
    #1 chk("flush stall_f", 64'(stallF), 64'h0);
    step();
    chk("flush valid_e", 64'(validE), 64'h0);
    chk("flush mem_write_e", 64'(memWriteE), 64'h0);
    flushD = 1'b0;

    // flush concurrent with load-use hazard
    issue(32'h0000A283, 32'h510);
    q.push_back(mk(32'h510, 32'hDEAD, 32'd0, 32'd0, 5'd1, 5'd0, 5'd5, LW_C));
    step();
    issue(32'h0050A223, 32'h514);
    flushD = 1'b1;
    #1 chk("flush+hazard stall_f", 64'(stallF), 64'h0);
    step();
    chk("flush+hazard valid_e", 64'(validE), 64'h0);
    chk("flush+hazard mem_write_e", 64'(memWriteE), 64'h0);
    flushD = 1'b0;

    // flush concurrent with stall_e holds, then bubbles once the hold drops
    issue(32'h002081B3, 32'h520);
    q.push_back(mk(32'h520, 32'hDEAD, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, ADD_C));
    step();
    stallE = 1'b1; flushD = 1'b1;
    issue(32'h0020A223, 32'h524);
    #1 chk("flush+stall stall_f", 64'(stallF), 64'h1);
    step();
    chk("flush+stall valid_e", 64'(validE), 64'h1);
    chk("flush+stall pc_e", 64'(pcE), 64'h520);
    stallE = 1'b0;
    #1 chk("flush after stall stall_f", 64'(stallF), 64'h0);
    step();
    chk("flush after stall valid_e", 64'(validE), 64'h0);
    chk("flush after stall mem_write_e", 64'(memWriteE), 64'h0);
    flushD = 1'b0;

    // reset asserted mid-stall
    issue(32'h002081B3, 32'h530);
    q.push_back(mk(32'h530, 32'hDEAD, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, ADD_C));
    step();
    stallE = 1'b1; reset = 1'b1;
    step();
    chk("reset mid-stall valid_e", 64'(validE), 64'h0);
    chk("reset mid-stall pc_e", 64'(pcE), 64'h0);
    reset = 1'b0; stallE = 1'b0; validD = 1'b0;
    step();

    // RV32E: x20 is out of range, x4 must not alias it, x15 is real
    eWr(4'd15, 32'h1515);
    eWr(4'd4, 32'h44);
    eInstrD = 32'h00FA00B3; ePcD = 32'h600; eValidD = 1'b1;
    qE.push_back(mk(32'h600, 32'd0, 32'h1515, 32'd0, 5'd0, 5'd15, 5'd1, ADD_C));
    step();
    eInstrD = 32'h00500A13; ePcD = 32'h604;
    qE.push_back(mk(32'h604, 32'd0, 32'd0, 32'd5, 5'd0, 5'd5, 5'd0, 6'b000100));
    step();
    eInstrD = 32'h00F20133; ePcD = 32'h608;
    qE.push_back(mk(32'h608, 32'h44, 32'h1515, 32'd0, 5'd4, 5'd15, 5'd2, ADD_C));
    step();
    eValidD = 1'b0;
    step(); step();

    chk("scoreboard drained", 64'(q.size()), 64'h0);
    chk("rv32e scoreboard drained", 64'(qE.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
